// File: rtl/t5_pkg.sv
// Shared definitions for the t5 fetch/execute blocks: FSM encoding, hart-count
// derivation and the default reset PC.
package t5_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic int unsigned nhart_of(input int unsigned hbit);
    return 32'd1 << hbit;
  endfunction

endpackage

// File: rtl/t5_rrarb.sv
// Combinational round-robin grant: the first requester strictly after ptr,
// searched cyclically, so ptr itself has the lowest priority.
module t5_rrarb
  import t5_pkg::*;
#(
  parameter  int unsigned HBIT  = 2,
  localparam int unsigned NHART = nhart_of(HBIT)
) (
  input  logic [NHART-1:0] req,
  input  logic [HBIT-1:0]  ptr,
  output logic             gnt_vld,
  output logic [HBIT-1:0]  gnt_id
);

  logic [HBIT-1:0] idx;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int unsigned k = 1; k <= NHART; k++) begin
      // k == NHART wraps back onto ptr itself
      idx = ptr + HBIT'(k);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

endmodule

// File: rtl/t5_fetch.sv
// Multi-hart instruction fetch: round-robin issue over a strobe/ack bus with one
// outstanding instruction per hart until execute writes back its next PC.
module t5_fetch
  import t5_pkg::*;
#(
  parameter  int unsigned     XLEN     = 32,
  parameter  int unsigned     HBIT     = 2,
  parameter  logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  localparam int unsigned     NHART    = nhart_of(HBIT)
) (
  input  logic             sclk,
  input  logic             srst,
  input  logic             sena,
  input  logic [NHART-1:0] hena,
  output logic [XLEN-3:0]  iadr,
  output logic             istb,
  input  logic             iack,
  input  logic [XLEN-1:0]  idat,
  output logic             fvld,
  output logic [XLEN-1:0]  finst,
  output logic [XLEN-1:0]  fpc,
  output logic [HBIT-1:0]  fhart,
  input  logic             xvld,
  input  logic [HBIT-1:0]  xhart,
  input  logic             xbra,
  input  logic [XLEN-1:0]  xbpc,
  input  logic [XLEN-1:0]  xpc
);

  fetch_state_e    state;
  logic [HBIT-1:0] ptr;
  logic [HBIT-1:0] gnt;
  logic [NHART-1:0] busy;
  logic [XLEN-3:0] pcw [NHART];

  logic [NHART-1:0] elig;
  logic             gnt_vld;
  logic [HBIT-1:0]  gnt_id;
  logic [XLEN-1:0]  wb_pc;
  logic             arb;
  logic             unused_lsb;

  // PCs are word aligned, so only word addresses are stored
  assign wb_pc      = xbra ? xbpc : xpc;
  assign unused_lsb = ^wb_pc[1:0];

  // Registered busy: a same-cycle writeback does not make its hart eligible yet
  assign elig = hena & ~busy;
  assign arb  = (state == StIdle) || iack;

  t5_rrarb #(
    .HBIT(HBIT)
  ) u_rrarb (
    .req    (elig),
    .ptr    (ptr),
    .gnt_vld(gnt_vld),
    .gnt_id (gnt_id)
  );

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      state <= StIdle;
      ptr   <= HBIT'(NHART - 1);
      gnt   <= '0;
      busy  <= '0;
      for (int h = 0; h < NHART; h++) pcw[h] <= RESET_PC[XLEN-1:2];
      istb  <= 1'b0;
      iadr  <= '0;
      fvld  <= 1'b0;
      finst <= '0;
      fpc   <= '0;
      fhart <= '0;
    end else if (sena) begin
      fvld <= 1'b0;
      if (xvld) begin
        pcw[xhart]  <= wb_pc[XLEN-1:2];
        busy[xhart] <= 1'b0;
      end
      if (state == StWait && iack) begin
        finst <= idat;
        fpc   <= {iadr, 2'b00};
        fhart <= gnt;
        fvld  <= 1'b1;
      end
      if (arb) begin
        if (gnt_vld) begin
          // Issued after the writeback clear, so a new grant keeps its hart busy
          gnt          <= gnt_id;
          ptr          <= gnt_id;
          iadr         <= pcw[gnt_id];
          istb         <= 1'b1;
          busy[gnt_id] <= 1'b1;
          state        <= StWait;
        end else begin
          istb  <= 1'b0;
          state <= StIdle;
        end
      end
    end
  end

endmodule

// File: tb/tb_t5_fetch.sv
// Bench for t5_fetch: transaction-level model checked every cycle, plus directed
// scenarios with literal expectations on the fetch log.
module tb_t5_fetch;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned HBIT  = 2;
  localparam int unsigned NHART = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic             sclk = 1'b0;
  logic             srst = 1'b0;
  logic             sena;
  logic [NHART-1:0] hena;
  logic [XLEN-3:0]  iadr;
  logic             istb;
  logic             iack;
  logic [XLEN-1:0]  idat;
  logic             fvld;
  logic [XLEN-1:0]  finst;
  logic [XLEN-1:0]  fpc;
  logic [HBIT-1:0]  fhart;
  logic             xvld;
  logic [HBIT-1:0]  xhart;
  logic             xbra;
  logic [XLEN-1:0]  xbpc;
  logic [XLEN-1:0]  xpc;

  always #5 sclk = ~sclk;

  t5_fetch #(
    .XLEN    (XLEN),
    .HBIT    (HBIT),
    .RESET_PC(RST_PC)
  ) dut (
    .sclk (sclk),
    .srst (srst),
    .sena (sena),
    .hena (hena),
    .iadr (iadr),
    .istb (istb),
    .iack (iack),
    .idat (idat),
    .fvld (fvld),
    .finst(finst),
    .fpc  (fpc),
    .fhart(fhart),
    .xvld (xvld),
    .xhart(xhart),
    .xbra (xbra),
    .xbpc (xbpc),
    .xpc  (xpc)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per-hart PC and busy flags, last-granted hart, and the one outstanding fetch
  logic [31:0] m_pc [NHART];
  bit          m_busy [NHART];
  int          m_ptr;
  int          m_out;
  logic [31:0] m_out_pc;
  bit          m_fv;
  logic [31:0] m_finst;
  logic [31:0] m_fpc;
  int          m_fhart;

  always @(posedge sclk or posedge srst) begin
    int          nxt;
    int          h;
    bit          ack;
    logic [31:0] npc;
    if (srst) begin
      for (int i = 0; i < NHART; i++) begin
        m_pc[i]   = RST_PC;
        m_busy[i] = 0;
      end
      m_ptr = NHART - 1;
      m_out = -1;
      m_out_pc = 0;
      m_fv = 0;
      m_finst = 0;
      m_fpc = 0;
      m_fhart = 0;
    end else if (sena) begin
      ack  = (m_out >= 0) && iack;
      m_fv = 0;
      if (ack) begin
        m_fv    = 1;
        m_finst = idat;
        m_fpc   = m_out_pc;
        m_fhart = m_out;
      end
      nxt = -1;
      if (m_out < 0 || ack) begin
        for (int k = 1; k <= NHART; k++) begin
          h = (m_ptr + k) % NHART;
          if (nxt < 0 && hena[h] && !m_busy[h]) nxt = h;
        end
      end
      npc = (nxt >= 0) ? m_pc[nxt] : 32'h0;
      if (xvld) begin
        m_pc[xhart]   = (xbra ? xbpc : xpc) & 32'hFFFF_FFFC;
        m_busy[xhart] = 0;
      end
      if (m_out < 0 || ack) begin
        m_out = nxt;
        if (nxt >= 0) begin
          m_out_pc     = npc;
          m_busy[nxt]  = 1;
          m_ptr        = nxt;
        end
      end
    end
  end

  always @(negedge sclk) begin
    if (!srst) begin
      chk("istb", istb, m_out >= 0);
      if (m_out >= 0) chk("iadr", iadr, m_out_pc[31:2]);
      chk("fvld", fvld, m_fv);
      if (m_fv) begin
        chk("finst", finst, m_finst);
        chk("fpc", fpc, m_fpc);
        chk("fhart", fhart, m_fhart);
      end
    end
  end

  int          lh[$];
  logic [31:0] lp[$];

  always @(negedge sclk) begin
    if (!srst && fvld) begin
      lh.push_back(int'(fhart));
      lp.push_back(fpc);
    end
  end

  task automatic tick();
    @(posedge sclk);
    #1;
    idat = idat + 32'h0101_0101;
  endtask

  task automatic wb(input int h, input logic [31:0] pcv, input bit bra, input logic [31:0] tgt);
    xvld  = 1'b1;
    xhart = HBIT'(h);
    xbra  = bra;
    xbpc  = tgt;
    xpc   = pcv;
    tick();
    xvld  = 1'b0;
  endtask

  task automatic chk_log(input string nm, input int i, input int h, input logic [31:0] p);
    if (i >= lh.size()) chk({nm, "_missing"}, lh.size(), i + 1);
    else begin
      chk({nm, "_hart"}, lh[i], h);
      chk({nm, "_pc"}, lp[i], p);
    end
  endtask

  initial begin
    sena = 1'b1; hena = '0; iack = 1'b0; idat = 32'h1234_0000;
    xvld = 1'b0; xhart = '0; xbra = 1'b0; xbpc = '0; xpc = '0;
    #1 srst = 1'b1;
    #20;
    chk("rst_istb", istb, 1'b0);
    chk("rst_fvld", fvld, 1'b0);
    chk("rst_iadr", iadr, 30'h0);
    chk("rst_fpc", fpc, 32'h0);

    // All harts, zero-wait memory
    hena = 4'hF;
    iack = 1'b1;
    tick();
    srst = 1'b0;
    repeat (8) tick();
    chk("p1_count", lh.size(), 4);
    for (int i = 0; i < 4; i++) chk_log("p1", i, i, 32'h0);
    chk("p1_idle", istb, 1'b0);

    // Sequential writeback of hart 2
    lh.delete(); lp.delete();
    wb(2, 32'h4, 1'b0, 32'h0);
    tick();
    chk("p2_istb", istb, 1'b1);
    chk("p2_iadr", iadr, 30'h1);
    repeat (4) tick();
    chk("p2_count", lh.size(), 1);
    chk_log("p2", 0, 2, 32'h4);

    // Taken branch for hart 1
    lh.delete(); lp.delete();
    wb(1, 32'h8, 1'b1, 32'h1000_0040);
    tick();
    chk("p3_iadr", iadr, 30'h0400_0010);
    repeat (4) tick();
    chk_log("p3", 0, 1, 32'h1000_0040);

    // Wait states with sena dropping mid-wait; xvld while sena low is ignored
    lh.delete(); lp.delete();
    iack = 1'b0;
    wb(0, 32'h8, 1'b0, 32'h0);
    tick();
    chk("p4_istb0", istb, 1'b1);
    chk("p4_iadr0", iadr, 30'h2);
    tick();
    chk("p4_iadr1", iadr, 30'h2);
    sena = 1'b0; xvld = 1'b1; xhart = 2'd3; xbra = 1'b0; xpc = 32'h40;
    tick();
    chk("p4_istb2", istb, 1'b1);
    chk("p4_iadr2", iadr, 30'h2);
    xvld = 1'b0;
    tick();
    chk("p4_iadr3", iadr, 30'h2);
    chk("p4_fvld3", fvld, 1'b0);
    sena = 1'b1;
    tick();
    chk("p4_iadr4", iadr, 30'h2);
    iack = 1'b1;
    tick();
    chk("p4_fvld", fvld, 1'b1);
    repeat (3) tick();
    chk("p4_drop", istb, 1'b0);
    chk("p4_pulses", lh.size(), 1);
    chk_log("p4", 0, 0, 32'h8);

    // Only harts 0 and 2 enabled
    lh.delete(); lp.delete();
    hena = 4'b0101;
    for (int r = 0; r < 4; r++) begin
      wb(0, 32'h200 + 32'(16 * r), 1'b0, 32'h0);
      wb(2, 32'h300 + 32'(16 * r), 1'b0, 32'h0);
      wb(1, 32'h500, 1'b0, 32'h0);
      wb(3, 32'h600, 1'b0, 32'h0);
      repeat (3) tick();
    end
    chk("p5_count", lh.size(), 8);
    for (int r = 0; r < 4; r++) begin
      chk_log("p5_h0", 2 * r, 0, 32'h200 + 32'(16 * r));
      chk_log("p5_h2", 2 * r + 1, 2, 32'h300 + 32'(16 * r));
    end

    // Asynchronous reset in the middle of a wait
    hena = 4'hF;
    iack = 1'b0;
    tick();
    tick();
    chk("p6_istb", istb, 1'b1);
    chk("p6_iadr", iadr, 30'h180);
    @(posedge sclk);
    #3 srst = 1'b1;
    #1;
    chk("p6_async_istb", istb, 1'b0);
    iack = 1'b1;
    lh.delete(); lp.delete();
    tick();
    tick();
    srst = 1'b0;
    repeat (8) tick();
    chk("p6_count", lh.size(), 4);
    chk_log("p6_first", 0, 0, RST_PC);
    chk_log("p6_second", 1, 1, RST_PC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
